// File: rtl/dmem_pkg.sv
// Shared encodings and lane/extension helpers for the MEM-stage data memory.
package dmem_pkg;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;

  localparam int MMIO_MAX_PORTS = 8;

  // The MMIO window is selected by the top address bit.
  function automatic int mmio_sel_bit(input int addr_w);
    return addr_w - 1;
  endfunction

  function automatic logic [1:0] align_lane(input logic [1:0] size, input logic [1:0] lane);
    case (size)
      SZ_B:    return lane;
      SZ_H:    return {lane[1], 1'b0};
      default: return 2'b00;
    endcase
  endfunction

  function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] addr);
    case (size)
      SZ_B:    return 4'b0001 << addr;
      SZ_H:    return addr[1] ? 4'b1100 : 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] store_replicate(input logic [1:0] size, input logic [31:0] wdata);
    case (size)
      SZ_B:    return {4{wdata[7:0]}};
      SZ_H:    return {2{wdata[15:0]}};
      default: return wdata;
    endcase
  endfunction

  function automatic logic [31:0] load_extend(input logic [31:0] word, input logic [1:0] size,
                                              input logic [1:0] addr, input logic is_unsigned);
    logic [31:0] sh;
    sh = word >> {addr, 3'b000};
    case (size)
      SZ_B:    return is_unsigned ? {24'b0, sh[7:0]}  : {{24{sh[7]}}, sh[7:0]};
      SZ_H:    return is_unsigned ? {16'b0, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
      default: return sh;
    endcase
  endfunction

endpackage

// File: rtl/data_mem_mmio_if.sv
// Request/response bus between the MEM stage and the data memory.
interface data_mem_mmio_if #(
  parameter int ADDR_W = 12
) ();
  logic              req_valid;
  logic              req_we;
  logic [1:0]        req_size;
  logic              req_unsigned;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic              stall;
  logic [31:0]       rdata;
  logic              fault;

  modport master (
    output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, stall,
    input  rdata, fault
  );

  modport slave (
    input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, stall,
    output rdata, fault
  );
endinterface

// File: rtl/dmem_sync2.sv
// Two-flop synchroniser for one asynchronous input port.
module dmem_sync2 #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  logic [W-1:0] s1_d, s1_q, s2_d, s2_q;

  always_comb begin
    s1_d = d;
    s2_d = s1_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q <= '0;
      s2_q <= '0;
    end else begin
      s1_q <= s1_d;
      s2_q <= s2_d;
    end
  end

  assign q = s2_q;
endmodule

// File: rtl/data_mem_mmio.sv
// MEM-stage data memory: byte/half/word RAM with registered read plus an MMIO window
// of synchronised inputs and output registers. DMEM_MISALIGN_TRAP_EN enables misalignment faults.
module data_mem_mmio
  import dmem_pkg::*;
#(
  parameter int DEPTH  = 512,
  parameter int ADDR_W = 12,
  parameter int N_IN   = 2,
  parameter int IN_W   = 8,
  parameter int N_OUT  = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  data_mem_mmio_if.slave        bus,
  input  logic [N_IN*IN_W-1:0]  in_port,
  output logic [N_OUT*32-1:0]   out_port
);
  localparam int IDX_W    = $clog2(DEPTH);
  localparam int MMIO_BIT = mmio_sel_bit(ADDR_W);

  if (N_IN > MMIO_MAX_PORTS || N_OUT > MMIO_MAX_PORTS) begin : g_bad_cfg
    $error("data_mem_mmio: too many MMIO ports");
  end

  logic [IN_W-1:0] in_sync [N_IN];

  for (genvar g = 0; g < N_IN; g++) begin : g_sync
    dmem_sync2 #(.W(IN_W)) u_sync (
      .clk (clk),
      .rst (rst),
      .d   (in_port[g*IN_W +: IN_W]),
      .q   (in_sync[g])
    );
  end

  logic             accept, is_mmio, misalign, wr_en, ram_we, ram_rd_en;
  logic [1:0]       lane;
  logic [3:0]       be;
  logic [31:0]      wdata_rep, mmio_rd;
  logic [IDX_W-1:0] ram_idx;
  int               k_i;
  logic             unused_addr;

  assign unused_addr = ^bus.req_addr;

  always_comb begin
    accept    = bus.req_valid & ~bus.stall;
    is_mmio   = bus.req_addr[MMIO_BIT];
`ifdef DMEM_MISALIGN_TRAP_EN
    misalign  = ((bus.req_size == SZ_H) && bus.req_addr[0]) ||
                (bus.req_size[1] && (bus.req_addr[1:0] != 2'b00));
    lane      = bus.req_addr[1:0];
`else
    misalign  = 1'b0;
    lane      = align_lane(bus.req_size, bus.req_addr[1:0]);
`endif
    wr_en     = accept & bus.req_we & ~misalign;
    // A store coinciding with the reset edge must not reach the RAM.
    ram_we    = wr_en & ~is_mmio & ~rst;
    ram_rd_en = accept & ~is_mmio;
    be        = lane_mask(bus.req_size, lane);
    wdata_rep = store_replicate(bus.req_size, bus.req_wdata);
    ram_idx   = bus.req_addr[IDX_W+1:2];
    k_i       = int'(bus.req_addr[4:2]);
  end

  logic [31:0] out_d [N_OUT];
  logic [31:0] out_q [N_OUT];

  always_comb begin
    mmio_rd = '0;
    for (int i = 0; i < N_IN; i++)
      if (k_i == i) mmio_rd[IN_W-1:0] = in_sync[i];
    for (int j = 0; j < N_OUT; j++)
      if (k_i == N_IN + j) mmio_rd = out_q[j];
  end

  always_comb begin
    for (int j = 0; j < N_OUT; j++) begin
      out_d[j] = out_q[j];
      if (wr_en && is_mmio && (k_i == N_IN + j))
        for (int l = 0; l < 4; l++)
          if (be[l]) out_d[j][8*l +: 8] = wdata_rep[8*l +: 8];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int j = 0; j < N_OUT; j++) out_q[j] <= '0;
    end else begin
      for (int j = 0; j < N_OUT; j++) out_q[j] <= out_d[j];
    end
  end

  always_comb begin
    out_port = '0;
    for (int j = 0; j < N_OUT; j++) out_port[j*32 +: 32] = out_q[j];
  end

  // ---- stage boundary: RAM write and read-first registered read ----
  logic [31:0] mem [DEPTH] = '{default: '0};
  logic [31:0] ram_word_q, mmio_word_q;

  always_ff @(posedge clk) begin
    if (ram_we)
      for (int l = 0; l < 4; l++)
        if (be[l]) mem[ram_idx][8*l +: 8] <= wdata_rep[8*l +: 8];
    if (ram_rd_en) ram_word_q <= mem[ram_idx];
    if (accept && is_mmio) mmio_word_q <= mmio_rd;
  end

  logic       has_d, has_q, sel_mmio_d, sel_mmio_q, uns_d, uns_q, fault_d, fault_q;
  logic [1:0] size_d, size_q, lane_d, lane_q;

  always_comb begin
    has_d      = has_q;
    sel_mmio_d = sel_mmio_q;
    uns_d      = uns_q;
    fault_d    = fault_q;
    size_d     = size_q;
    lane_d     = lane_q;
    if (accept) begin
      has_d      = ~misalign;
      sel_mmio_d = is_mmio;
      uns_d      = bus.req_unsigned;
      fault_d    = misalign;
      size_d     = bus.req_size;
      lane_d     = lane;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      has_q      <= 1'b0;
      sel_mmio_q <= 1'b0;
      uns_q      <= 1'b0;
      fault_q    <= 1'b0;
      size_q     <= SZ_W;
      lane_q     <= 2'b00;
    end else begin
      has_q      <= has_d;
      sel_mmio_q <= sel_mmio_d;
      uns_q      <= uns_d;
      fault_q    <= fault_d;
      size_q     <= size_d;
      lane_q     <= lane_d;
    end
  end

  // ---- stage boundary: load alignment and extension ----
  logic [31:0] rd_word;

  always_comb begin
    rd_word   = sel_mmio_q ? mmio_word_q : ram_word_q;
    bus.rdata = has_q ? load_extend(rd_word, size_q, lane_q, uns_q) : 32'h0;
    bus.fault = fault_q;
  end

endmodule

// File: tb/tb_data_mem_mmio.sv
// Scoreboard bench for data_mem_mmio: expectations queued at issue, checked when rdata/fault appear.
module tb_data_mem_mmio;
  import dmem_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] in_port = '0;
  logic [63:0] out_port;

  always #5 clk = ~clk;

  data_mem_mmio_if #(.ADDR_W(12)) bus ();

  data_mem_mmio #(
    .DEPTH(512), .ADDR_W(12), .N_IN(2), .IN_W(8), .N_OUT(2)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .in_port  (in_port),
    .out_port (out_port)
  );

  typedef struct {
    string       tag;
    logic [31:0] rd;
    logic        f;
  } exp_t;

  exp_t sb_q [$];
  int   n_chk  = 0;
  int   n_pass = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic req(input bit we, input logic [1:0] sz, input bit uns, input logic [11:0] a,
                     input logic [31:0] wd, input string tag, input logic [31:0] exp_rd,
                     input bit exp_f);
    exp_t e;
    @(negedge clk);
    bus.req_valid    = 1'b1;
    bus.req_we       = we;
    bus.req_size     = sz;
    bus.req_unsigned = uns;
    bus.req_addr     = a;
    bus.req_wdata    = wd;
    sb_q.push_back('{tag, exp_rd, exp_f});
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    bus.req_we    = 1'b0;
    if (sb_q.size() == 0) begin
      chk({tag, "_sb_empty"}, 64'd0, 64'd1);
    end else begin
      e = sb_q.pop_front();
      chk({e.tag, "_rdata"}, {32'h0, bus.rdata}, {32'h0, e.rd});
      chk({e.tag, "_fault"}, {63'h0, bus.fault}, {63'h0, e.f});
    end
  endtask

  initial begin
    bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_size = SZ_W;
    bus.req_unsigned = 1'b0; bus.req_addr = '0; bus.req_wdata = '0; bus.stall = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_rdata", {32'h0, bus.rdata}, 64'h0);
    chk("rst_fault", {63'h0, bus.fault}, 64'h0);
    chk("rst_out",   out_port, 64'h0);
    @(negedge clk);
    rst = 1'b0;

    // Sub-word loads with sign/zero extension
    req(1, SZ_W, 0, 12'h010, 32'hDEADBEEF, "sw_010",  32'h00000000, 0);
    req(0, SZ_B, 0, 12'h013, 32'h0,        "lb_013",  32'hFFFFFFDE, 0);
    req(0, SZ_B, 1, 12'h013, 32'h0,        "lbu_013", 32'h000000DE, 0);
    req(0, SZ_H, 0, 12'h012, 32'h0,        "lh_012",  32'hFFFFDEAD, 0);
    req(0, SZ_H, 1, 12'h010, 32'h0,        "lhu_010", 32'h0000BEEF, 0);
    req(0, SZ_W, 0, 12'h010, 32'h0,        "lw_010",  32'hDEADBEEF, 0);

    // Byte-lane store followed immediately by a load of the same word
    req(1, SZ_W, 0, 12'h020, 32'h11223344, "sw_020", 32'h00000000, 0);
    req(1, SZ_B, 0, 12'h021, 32'h000000AA, "sb_021", 32'h00000033, 0);
    req(0, SZ_W, 0, 12'h020, 32'h0,        "lw_020", 32'h1122AA44, 0);

    // Input ports: two synchroniser cycles before the value is readable
    in_port = 16'h3C5A;
    req(0, SZ_W, 0, 12'h800, 32'h0,  "in0_c1",  32'h00000000, 0);
    req(0, SZ_W, 0, 12'h800, 32'h0,  "in0_c2",  32'h00000000, 0);
    req(0, SZ_W, 0, 12'h800, 32'h0,  "in0_c3",  32'h0000005A, 0);
    req(1, SZ_W, 0, 12'h800, 32'h77, "sw_in0",  32'h0000005A, 0);
    req(0, SZ_W, 0, 12'h800, 32'h0,  "in0_ro",  32'h0000005A, 0);
    req(0, SZ_W, 0, 12'h804, 32'h0,  "in1",     32'h0000003C, 0);
    req(0, SZ_W, 0, 12'h810, 32'h0,  "mmio_k4", 32'h00000000, 0);

    // Output registers and stall
    req(1, SZ_W, 0, 12'h808, 32'hCAFE0001, "sw_out0", 32'h00000000, 0);
    chk("out0", {32'h0, out_port[31:0]}, 64'hCAFE0001);
    req(0, SZ_W, 0, 12'h808, 32'h0, "lw_out0", 32'hCAFE0001, 0);
    @(negedge clk);
    bus.stall = 1'b1; bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_size = SZ_W;
    bus.req_addr = 12'h80C; bus.req_wdata = 32'h12345678;
    @(posedge clk);
    #1;
    chk("stall_out1",  {32'h0, out_port[63:32]}, 64'h0);
    chk("stall_rdata", {32'h0, bus.rdata}, 64'hCAFE0001);
    @(negedge clk);
    bus.req_addr = 12'h030;
    @(posedge clk);
    #1;
    bus.stall = 1'b0; bus.req_valid = 1'b0; bus.req_we = 1'b0;
    req(0, SZ_W, 0, 12'h030, 32'h0, "stall_ram", 32'h00000000, 0);
    req(1, SZ_H, 0, 12'h80E, 32'h0000BEEF, "sh_out1", 32'h00000000, 0);
    chk("out1_sh", {32'h0, out_port[63:32]}, 64'hBEEF0000);

    // Misaligned accesses
`ifdef DMEM_MISALIGN_TRAP_EN
    req(1, SZ_W, 0, 12'h022, 32'h55667788, "sw_mis", 32'h00000000, 1);
    req(0, SZ_W, 0, 12'h020, 32'h0,        "lw_mis", 32'h1122AA44, 0);
    req(0, SZ_H, 0, 12'h011, 32'h0,        "lh_mis", 32'h00000000, 1);
`else
    req(1, SZ_W, 0, 12'h022, 32'h55667788, "sw_mis", 32'h1122AA44, 0);
    req(0, SZ_W, 0, 12'h020, 32'h0,        "lw_mis", 32'h55667788, 0);
    req(0, SZ_H, 0, 12'h011, 32'h0,        "lh_mis", 32'hFFFFBEEF, 0);
`endif

    // Mid-run reset: outputs clear at once, RAM retained, store on reset edge dropped
    req(1, SZ_W, 0, 12'h808, 32'h00001234, "sw_out0b", 32'hCAFE0001, 0);
    chk("out0_1234", {32'h0, out_port[31:0]}, 64'h00001234);
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_size = SZ_W;
    bus.req_addr = 12'h010; bus.req_wdata = 32'h00000099;
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_rdata", {32'h0, bus.rdata}, 64'h0);
    chk("mid_rst_fault", {63'h0, bus.fault}, 64'h0);
    chk("mid_rst_out",   out_port, 64'h0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0; bus.req_valid = 1'b0; bus.req_we = 1'b0;
    req(0, SZ_W, 0, 12'h010, 32'h0, "ram_kept", 32'hDEADBEEF, 0);

    chk("sb_drained", {32'h0, 32'(sb_q.size())}, 64'h0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/data_mem_mmio.md
# data_mem_mmio

Parametrised data memory for the five-stage pipeline's MEM stage. It supports byte, half and word loads and stores with RISC-V sign/zero extension, and uses a registered read port so block RAM is inferred. Multiple synchronised input ports and resettable output registers sit in a memory-mapped I/O window. It replaces the fixed 512-word, single-switch, single-LED data file.

## Interface
- DEPTH, 512: data words in RAM; power of two.
- ADDR_W, 12: byte-address width; bit ADDR_W-1 selects MMIO. Requires DEPTH*4 <= 2^(ADDR_W-1).
- N_IN, 2: number of input ports; 1..8.
- IN_W, 8: width of each input port; 1..32.
- N_OUT, 2: number of 32-bit output registers; 1..8.
- clk  in  1  system clock; all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  1  access request this cycle.
- req_we  in  1  1 = store, 0 = load.
- req_size  in  2  0 = byte, 1 = half, 2 = word; 3 is treated as word.
- req_unsigned  in  1  load zero-extends (LBU/LHU).
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  32  store data, right-aligned.
- stall  in  1  hold rdata and fault; suppress all writes.
- rdata  out  32  load result, extended.
- fault  out  1  misaligned-access flag for the previous request.
- in_port  in  N_IN*IN_W  asynchronous inputs; port k occupies bits [k*IN_W +: IN_W].
- out_port  out  N_OUT*32  output registers; register k occupies bits [k*32 +: 32].

## Operation
- RAM region (addr[ADDR_W-1]=0):
  - Word index is addr[ADDR_W-2:2] modulo DEPTH.
  - Byte lane is addr[1:0].
  - Stores write only the addressed lanes: SB uses 1 lane, SH uses lanes {a1,0} and {a1,1}, SW uses all 4.
- MMIO region (addr[ADDR_W-1]=1): word index k = addr[4:2].
  - k < N_IN: reads the synchronised input port k, zero-extended. Stores are ignored.
  - N_IN <= k < N_IN+N_OUT: out register k-N_IN, readable and writable. Sub-word stores update only the addressed lanes.
  - Other k: reads 0, stores ignored.
- Load data path: the selected word is shifted right by 8*addr[1:0], masked to the access size, then sign- or zero-extended per req_unsigned.
- Input synchronisation: each input port passes through a 2-flop synchroniser.
- RAM contents are initialised to 0 at configuration and are not cleared by rst.

## Timing
- Reset values: rdata = 0, fault = 0, all out_port registers = 0, synchroniser flops = 0.
- Load latency is 1 cycle. A request accepted at edge N (req_valid=1, stall=0) drives rdata/fault after edge N and holds them until the next accepted request.
- Cycles with req_valid=0 leave rdata and fault unchanged.
- Stores commit at the accepting edge. A store's rdata is the pre-write word (read-first).
- A load and store to the same word in consecutive cycles: the load sees the new data.
- stall=1 freezes rdata, fault and all memory/out-register contents. Synchronisers keep running.
- Input ports have 2 cycles of synchroniser latency, plus 1 cycle of read latency.
- rst asserted mid-operation clears the outputs immediately. RAM keeps its contents. An in-flight store on the reset edge is dropped.

## Configuration
- DMEM_MISALIGN_TRAP_EN defined:
  - A half access with addr[0]=1, or a word access with addr[1:0]!=0, sets fault=1 with the load result.
  - The store is suppressed and rdata = 0.
- DMEM_MISALIGN_TRAP_EN undefined:
  - Low address bits are forced to alignment: half clears bit 0, word clears bits 1:0.
  - The access proceeds and fault is tied to 0.

## Structure
- Package dmem_pkg holds:
  - size encodings SZ_B/SZ_H/SZ_W;
  - the MMIO select bit position;
  - MMIO_MAX_PORTS = 8;
  - functions lane_mask(size, addr) and load_extend(word, size, addr, unsigned).
- One sub-module, dmem_sync2: a parametrised-width 2-flop synchroniser, one instance per input port.

## Test plan
- Reset (rst pulsed mid-run after out reg 0 = 0x1234) -> rdata=0, fault=0, out_port all 0; RAM word 4 keeps its value.
- SW 0xDEADBEEF @0x010; LB @0x013 -> 0xFFFFFFDE; LBU @0x013 -> 0x000000DE; LH @0x012 -> 0xFFFFDEAD; LHU @0x010 -> 0x0000BEEF.
- SW 0x11223344 @0x020, then SB 0xAA @0x021, then LW @0x020 -> 0x1122AA44. A load issued the cycle after the SB also returns 0x1122AA44.
- in_port[7:0] = 0x5A set at cycle 0; LW @0x800 issued at cycles 1, 2, 3 -> rdata 0 for the cycle-1 and cycle-2 requests, 0x5A for the cycle-3 request. SW 0x77 @0x800 has no effect.
- SW 0xCAFE0001 @0x808 -> out_port[31:0] = 0xCAFE0001. With stall=1, SW @0x80C leaves out register 1 at 0 and rdata unchanged.
- With DMEM_MISALIGN_TRAP_EN: SW @0x022 -> fault=1, word unchanged. Without it, the same store writes word 0x020 and fault=0.
